alignment_emitter: RTL
======================

// Module: alignment_emitter
// PURPOSE
//  Downstream of the NW grid. Captures the traceback coordinate stream, which arrives end-to-start at
//  one coord per cycle with no backpressure: (LENGTH-1,LENGTH-1) first, (0,0) last.
//  Reverses it in an internal LIFO and emits the alignment in forward order.
//  Each output is one alignment column (s1 char / s2 char / gap flags) on a valid/ready stream.
//  Feeds the host-side result writer.
// PARAMETERS
//  LENGTH       10          characters per string
//  CWIDTH       2           bits per character
//  CORD_LENGTH  8           bits per coordinate
//  DEPTH        2*LENGTH    LIFO entries (max traceback path is 2*LENGTH-1)
// PORTS
//  clk        in   1                   clock; all state on posedge
//  reset      in   1                   synchronous, active-high
//  s1         in   LENGTH*CWIDTH       string 1, char i at [i*CWIDTH+:CWIDTH] (indexed by y)
//  s2         in   LENGTH*CWIDTH       string 2, char i at [i*CWIDTH+:CWIDTH] (indexed by x)
//  coord_valid in  1                   coord_x/coord_y valid this cycle (no ready; always accepted)
//  coord_x    in   CORD_LENGTH         traceback column
//  coord_y    in   CORD_LENGTH         traceback row
//  out_valid  out  1                   alignment column available
//  out_ready  in   1                   consumer accepts column
//  out_c1     out  CWIDTH              s1 char, 0 when out_gap1
//  out_c2     out  CWIDTH              s2 char, 0 when out_gap2
//  out_gap1   out  1                   s1 side is a gap
//  out_gap2   out  1                   s2 side is a gap
//  out_last   out  1                   final column, i.e. (LENGTH-1,LENGTH-1)
//  done       out  1                   alignment fully emitted; held until reset
//  error      out  1                   sticky: overflow, illegal step, or input outside CAPTURE
// BEHAVIOUR
//  Reset: state=CAPTURE, LIFO empty. All outputs are 0.
//  States are CAPTURE, EMIT and DONE.
//  CAPTURE
//  - coord_valid: push {x,y}.
//  - Push when full (DEPTH entries): drop the coord, set error.
//  - Pushed coord==(0,0): next state EMIT.
//  EMIT
//  - Output register loads when (!out_valid || out_ready) and the LIFO is non-empty.
//  - A load pops the top entry p and compares it with prev, the previous popped coord.
//  - First pop:                  column (s1[p.y], s2[p.x]), no gaps.
//  - dx=1,dy=1:                  (s1[y], s2[x]), no gaps.
//  - dx=0,dy=1:                  (s1[y], gap); out_gap2=1, out_c2=0.
//  - dx=1,dy=0:                  (gap, s2[x]); out_gap1=1, out_c1=0.
//  - Any other delta:            set error; emit as no-gap column.
//  - out_last=1 on the column loaded from the final (bottom) LIFO entry.
//  - out_* hold stable while out_valid && !out_ready.
//  - out_valid clears after out_last is accepted; next state DONE.
//  DONE
//  - done=1, out_valid=0. Leaves only on reset.
//  Latency: (0,0) pushed in cycle N -> EMIT in N+1 -> out_valid=1 in N+2.
//  With out_ready held at 1: one column per cycle.
//  Inputs outside CAPTURE: coord_valid in EMIT/DONE is ignored and sets error.
//  Reset mid-operation: clears the LIFO, out_valid, done and error; returns to CAPTURE.
//  Coordinates >= LENGTH: set error; char index wraps modulo port width, no X.
// TESTING
//  1. LENGTH=4, s1=s2={0,1,2,3}; coords (3,3),(2,2),(1,1),(0,0)
//     -> 4 columns (0,0),(1,1),(2,2),(3,3); no gaps; out_last on 4th; done; error=0.
//  2. LENGTH=4; coords (3,3),(2,3),(1,2),(0,1),(0,0)
//     -> 5 columns: (s1[0],s2[0]), (s1[1],gap), (s1[2],s2[1]), (s1[3],s2[2]), (gap,s2[3]) last.
//  3. Case 1 with out_ready low on cycles N+2..N+5
//     -> out_valid=1 and column (0,0) held stable; no pop; order intact after release.
//  4. DEPTH=4; push 5 coords ending (0,0)
//     -> error=1 from the 5th push; only the first 4 are emitted.
//  5. Coords (3,3),(1,1),(0,0) -> error=1 on the (1,1)->(3,3) step; 3 columns still emitted.
//  6. reset asserted mid-EMIT after 2 columns
//     -> next cycle: out_valid=0, done=0, error=0; a fresh case-1 stream emits correctly.

Source files
------------

// File: rtl/alignment_emitter_if.sv
// Stream bundle between the traceback source, the alignment emitter and the result writer.
// The master drives the coordinates and accepts the columns; the slave is the emitter.
interface alignment_emitter_if #(
  parameter int CWIDTH      = 2,
  parameter int CORD_LENGTH = 8
);
  logic                   coord_valid;
  logic [CORD_LENGTH-1:0] coord_x;
  logic [CORD_LENGTH-1:0] coord_y;
  logic                   out_valid;
  logic                   out_ready;
  logic [CWIDTH-1:0]      out_c1;
  logic [CWIDTH-1:0]      out_c2;
  logic                   out_gap1;
  logic                   out_gap2;
  logic                   out_last;

  modport master (
    output coord_valid, coord_x, coord_y, out_ready,
    input  out_valid, out_c1, out_c2, out_gap1, out_gap2, out_last
  );

  modport slave (
    input  coord_valid, coord_x, coord_y, out_ready,
    output out_valid, out_c1, out_c2, out_gap1, out_gap2, out_last
  );
endinterface

// File: rtl/alignment_emitter.sv
// Captures the end-to-start traceback path into a LIFO, then replays it start-to-end as
// alignment columns (char pair plus gap flags) on a valid/ready stream.
module alignment_emitter #(
  parameter int LENGTH      = 10,
  parameter int CWIDTH      = 2,
  parameter int CORD_LENGTH = 8,
  parameter int DEPTH       = 2 * LENGTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LENGTH*CWIDTH-1:0] s1,
  input  logic [LENGTH*CWIDTH-1:0] s2,
  alignment_emitter_if.slave       bus,
  output logic                     done,
  output logic                     error
);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int EW    = 2 * CORD_LENGTH;

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_EMIT    = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [PTR_W-1:0]       cnt_q, cnt_d;
  logic [CORD_LENGTH-1:0] prev_x_q, prev_x_d;
  logic [CORD_LENGTH-1:0] prev_y_q, prev_y_d;
  logic                   first_q, first_d;
  logic                   out_valid_q, out_valid_d;
  logic [CWIDTH-1:0]      out_c1_q, out_c1_d;
  logic [CWIDTH-1:0]      out_c2_q, out_c2_d;
  logic                   out_gap1_q, out_gap1_d;
  logic                   out_gap2_q, out_gap2_d;
  logic                   out_last_q, out_last_d;
  logic                   error_q, error_d;

  logic [EW-1:0]          lifo_mem [DEPTH];
  logic                   push_en;
  logic [AW-1:0]          wr_addr;
  logic [AW-1:0]          rd_addr;
  logic [EW-1:0]          top_entry;
  logic [CORD_LENGTH-1:0] top_x, top_y;
  logic [CORD_LENGTH-1:0] dx, dy;
  logic [IDX_W-1:0]       x_idx, y_idx;
  logic                   load;
  logic                   coord_is_origin;
  logic                   coord_out_of_range;

  logic [CWIDTH-1:0] s1_chars [LENGTH];
  logic [CWIDTH-1:0] s2_chars [LENGTH];

  for (genvar gi = 0; gi < LENGTH; gi++) begin : g_chars
    assign s1_chars[gi] = s1[gi*CWIDTH +: CWIDTH];
    assign s2_chars[gi] = s2[gi*CWIDTH +: CWIDTH];
  end

  // The top entry must be visible in the same cycle it is popped, so the LIFO is read asynchronously.
  assign wr_addr   = AW'(cnt_q);
  assign rd_addr   = AW'(cnt_q - PTR_W'(1));
  assign top_entry = lifo_mem[rd_addr];
  assign top_x     = top_entry[EW-1:CORD_LENGTH];
  assign top_y     = top_entry[CORD_LENGTH-1:0];
  assign dx        = top_x - prev_x_q;
  assign dy        = top_y - prev_y_q;
  assign x_idx     = IDX_W'(top_x % CORD_LENGTH'(LENGTH));
  assign y_idx     = IDX_W'(top_y % CORD_LENGTH'(LENGTH));

  assign coord_is_origin    = (bus.coord_x == '0) && (bus.coord_y == '0);
  assign coord_out_of_range = (bus.coord_x >= CORD_LENGTH'(LENGTH)) ||
                              (bus.coord_y >= CORD_LENGTH'(LENGTH));
  assign load = (state_q == ST_EMIT) && (!out_valid_q || bus.out_ready) && (cnt_q != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CAPTURE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CAPTURE: if (bus.coord_valid && coord_is_origin) state_d = ST_EMIT;
      ST_EMIT:    if (out_valid_q && bus.out_ready && out_last_q) state_d = ST_DONE;
      ST_DONE:    state_d = ST_DONE;
      default:    state_d = ST_CAPTURE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    prev_x_d    = prev_x_q;
    prev_y_d    = prev_y_q;
    first_d     = first_q;
    out_valid_d = out_valid_q;
    out_c1_d    = out_c1_q;
    out_c2_d    = out_c2_q;
    out_gap1_d  = out_gap1_q;
    out_gap2_d  = out_gap2_q;
    out_last_d  = out_last_q;
    error_d     = error_q;
    push_en     = 1'b0;

    if (state_q == ST_CAPTURE) begin
      if (bus.coord_valid) begin
        if (coord_out_of_range) error_d = 1'b1;
        // A full LIFO drops the coord, but (0,0) still ends capture so the kept prefix is emitted.
        if (cnt_q == PTR_W'(DEPTH)) begin
          error_d = 1'b1;
        end else begin
          push_en = 1'b1;
          cnt_d   = cnt_q + PTR_W'(1);
        end
      end
    end else if (bus.coord_valid) begin
      error_d = 1'b1;
    end

    if (load) begin
      cnt_d       = cnt_q - PTR_W'(1);
      prev_x_d    = top_x;
      prev_y_d    = top_y;
      first_d     = 1'b0;
      out_valid_d = 1'b1;
      out_last_d  = (cnt_q == PTR_W'(1));
      out_c1_d    = s1_chars[y_idx];
      out_c2_d    = s2_chars[x_idx];
      out_gap1_d  = 1'b0;
      out_gap2_d  = 1'b0;
      if (!first_q) begin
        if (dx == CORD_LENGTH'(1) && dy == CORD_LENGTH'(1)) begin
          out_gap1_d = 1'b0;
        end else if (dx == '0 && dy == CORD_LENGTH'(1)) begin
          out_gap2_d = 1'b1;
          out_c2_d   = '0;
        end else if (dx == CORD_LENGTH'(1) && dy == '0) begin
          out_gap1_d = 1'b1;
          out_c1_d   = '0;
        end else begin
          error_d = 1'b1;
        end
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
      if (out_last_q) begin
        out_c1_d   = '0;
        out_c2_d   = '0;
        out_gap1_d = 1'b0;
        out_gap2_d = 1'b0;
        out_last_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      prev_x_q    <= '0;
      prev_y_q    <= '0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_c1_q    <= '0;
      out_c2_q    <= '0;
      out_gap1_q  <= 1'b0;
      out_gap2_q  <= 1'b0;
      out_last_q  <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      prev_x_q    <= prev_x_d;
      prev_y_q    <= prev_y_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_c1_q    <= out_c1_d;
      out_c2_q    <= out_c2_d;
      out_gap1_q  <= out_gap1_d;
      out_gap2_q  <= out_gap2_d;
      out_last_q  <= out_last_d;
      error_q     <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) lifo_mem[wr_addr] <= {bus.coord_x, bus.coord_y};
  end

  always_comb begin
    bus.out_valid = out_valid_q;
    bus.out_c1    = out_c1_q;
    bus.out_c2    = out_c2_q;
    bus.out_gap1  = out_gap1_q;
    bus.out_gap2  = out_gap2_q;
    bus.out_last  = out_last_q;
    done          = (state_q == ST_DONE);
    error         = error_q;
  end
endmodule
